// File: rtl/cpp_internal_bool_sync_deglitch.sv
// Clocked consumer for the hysteresis converter: synchronizes the async bit and event line,
// debounces over FILT_LEN sample events, emits edge pulses and measures the rising-edge period.
module cpp_internal_bool_sync_deglitch #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             update_in,
  output logic             out,
  output logic             update_out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow
);

  typedef enum logic [1:0] {StLow, StLowPend, StHigh, StHighPend} state_e;

  localparam logic [3:0]       FiltLen = 4'(FILT_LEN);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             in_s1_q, in_s2_q;
  logic             upd_s1_q, upd_s2_q, upd_s3_q;
  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             out_q, out_d;
  logic             upd_out_q, upd_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             armed_q, armed_d;
  logic             ev;
  logic             sample;

  // A level change on the synchronized event line is one sample.
  assign ev     = upd_s2_q ^ upd_s3_q;
  assign sample = in_s2_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (ev) begin
      unique case (state_q)
        StLow: begin
          if (sample) begin
            if (FiltLen == 4'd1) begin
              state_d = StHigh;
              fcnt_d  = '0;
            end else begin
              state_d = StLowPend;
              fcnt_d  = 4'd1;
            end
          end
        end
        StLowPend: begin
          if (!sample) begin
            state_d = StLow;
            fcnt_d  = '0;
          end else if (fcnt_q + 4'd1 == FiltLen) begin
            state_d = StHigh;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 4'd1;
          end
        end
        StHigh: begin
          if (!sample) begin
            if (FiltLen == 4'd1) begin
              state_d = StLow;
              fcnt_d  = '0;
            end else begin
              state_d = StHighPend;
              fcnt_d  = 4'd1;
            end
          end
        end
        StHighPend: begin
          if (sample) begin
            state_d = StHigh;
            fcnt_d  = '0;
          end else if (fcnt_q + 4'd1 == FiltLen) begin
            state_d = StLow;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 4'd1;
          end
        end
        default: begin
          state_d = StLow;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    out_d     = (state_d == StHigh) || (state_d == StHighPend);
    rise_d    = out_d & ~out_q;
    fall_d    = ~out_d & out_q;
    upd_out_d = upd_out_q ^ ev;

    pcnt_d   = pcnt_q;
    period_d = period_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    armed_d  = armed_q;
    if (rise_q) begin
      pcnt_d  = CntOne;
      armed_d = 1'b1;
      // The first rise after reset only opens the measurement window.
      if (armed_q) begin
        period_d = pcnt_q;
        ovf_d    = (pcnt_q == CntMax);
        valid_d  = 1'b1;
      end
    end else if (pcnt_q != CntMax) begin
      pcnt_d = pcnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_s1_q   <= 1'b0;
      in_s2_q   <= 1'b0;
      upd_s1_q  <= 1'b0;
      upd_s2_q  <= 1'b0;
      upd_s3_q  <= 1'b0;
      state_q   <= StLow;
      fcnt_q    <= '0;
      out_q     <= 1'b0;
      upd_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pcnt_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      in_s1_q   <= in;
      in_s2_q   <= in_s1_q;
      upd_s1_q  <= update_in;
      upd_s2_q  <= upd_s1_q;
      upd_s3_q  <= upd_s2_q;
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      out_q     <= out_d;
      upd_out_q <= upd_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pcnt_q    <= pcnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      armed_q   <= armed_d;
    end
  end

  assign out          = out_q;
  assign update_out   = upd_out_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_cpp_internal_bool_sync_deglitch.sv
// Drives three differently parameterized copies from one stimulus stream and checks each
// against an event-level debounce/period model.
module tb_cpp_internal_bool_sync_deglitch;

  localparam int NI = 3;

  function automatic int unsigned fl_of(input int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 2;
  endfunction

  function automatic int unsigned cw_of(input int i);
    return (i == 0) ? 16 : (i == 1) ? 4 : 8;
  endfunction

  logic        clk;
  logic        rst_n;
  logic        in_b;
  logic        upd_b;
  logic        out_w      [NI];
  logic        updout_w   [NI];
  logic        rise_w     [NI];
  logic        fall_w     [NI];
  logic [31:0] period_w   [NI];
  logic        valid_w    [NI];
  logic        ovf_w      [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [cw_of(gi)-1:0] per;
    cpp_internal_bool_sync_deglitch #(
      .FILT_LEN(fl_of(gi)),
      .CNT_W   (cw_of(gi))
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in          (in_b),
      .update_in   (upd_b),
      .out         (out_w[gi]),
      .update_out  (updout_w[gi]),
      .rise        (rise_w[gi]),
      .fall        (fall_w[gi]),
      .period      (per),
      .period_valid(valid_w[gi]),
      .overflow    (ovf_w[gi])
    );
    assign period_w[gi] = 32'(per);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per DUT copy.
  bit          m_out    [NI];
  int unsigned m_streak [NI];
  bit          m_upd    [NI];
  bit          m_armed  [NI];
  longint      m_trise  [NI];
  longint      m_period [NI];
  bit          m_valid  [NI];
  bit          m_ovf    [NI];
  bit          m_rise   [NI];
  bit          m_fall   [NI];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_out[i] = 0; m_streak[i] = 0; m_upd[i] = 0; m_armed[i] = 0;
      m_trise[i] = 0; m_period[i] = 0; m_valid[i] = 0; m_ovf[i] = 0;
      m_rise[i] = 0; m_fall[i] = 0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s out[%0d]", tag, i), 32'(out_w[i]), 0);
      check_eq($sformatf("%s update_out[%0d]", tag, i), 32'(updout_w[i]), 0);
      check_eq($sformatf("%s rise[%0d]", tag, i), 32'(rise_w[i]), 0);
      check_eq($sformatf("%s fall[%0d]", tag, i), 32'(fall_w[i]), 0);
      check_eq($sformatf("%s period[%0d]", tag, i), period_w[i], 0);
      check_eq($sformatf("%s period_valid[%0d]", tag, i), 32'(valid_w[i]), 0);
      check_eq($sformatf("%s overflow[%0d]", tag, i), 32'(ovf_w[i]), 0);
    end
  endtask

  // Called at the negedge where the event line changed; the outputs react on the
  // third following clock edge.
  task automatic event_accept(input bit v);
    longint e;
    longint d;
    longint mx;
    e = longint'(cyc) + 3;
    for (int i = 0; i < NI; i++) begin
      m_upd[i]  = ~m_upd[i];
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (v != m_out[i]) begin
        m_streak[i]++;
        if (m_streak[i] >= fl_of(i)) begin
          m_out[i]    = v;
          m_streak[i] = 0;
          m_rise[i]   = v;
          m_fall[i]   = !v;
        end
      end else begin
        m_streak[i] = 0;
      end
      if (m_rise[i]) begin
        if (m_armed[i]) begin
          d  = e - m_trise[i];
          mx = (longint'(1) << cw_of(i)) - 1;
          m_period[i] = (d >= mx) ? mx : d;
          m_ovf[i]    = (d >= mx);
          m_valid[i]  = 1;
        end
        m_armed[i] = 1;
        m_trise[i] = e;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("early update_out[%0d]", i), 32'(updout_w[i]), 32'(!m_upd[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("out[%0d]", i), 32'(out_w[i]), 32'(m_out[i]));
      check_eq($sformatf("update_out[%0d]", i), 32'(updout_w[i]), 32'(m_upd[i]));
      check_eq($sformatf("rise[%0d]", i), 32'(rise_w[i]), 32'(m_rise[i]));
      check_eq($sformatf("fall[%0d]", i), 32'(fall_w[i]), 32'(m_fall[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("rise end[%0d]", i), 32'(rise_w[i]), 0);
      check_eq($sformatf("fall end[%0d]", i), 32'(fall_w[i]), 0);
      check_eq($sformatf("period[%0d]", i), period_w[i], 32'(m_period[i]));
      check_eq($sformatf("period_valid[%0d]", i), 32'(valid_w[i]), 32'(m_valid[i]));
      check_eq($sformatf("overflow[%0d]", i), 32'(ovf_w[i]), 32'(m_ovf[i]));
    end
    @(negedge clk);
  endtask

  // Hold the bit for 'pre' cycles before the event line changes.
  task automatic send_sample(input bit v, input int unsigned pre);
    in_b = v;
    repeat (pre) @(negedge clk);
    upd_b = ~upd_b;
    event_accept(v);
  endtask

  // Asynchronous reset mid-cycle; a high event line at release looks like one sample.
  task automatic do_reset(input bit upd_level, input bit in_level);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    model_reset();
    in_b  = in_level;
    upd_b = upd_level;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    if (upd_level) event_accept(in_level);
    else repeat (4) @(negedge clk);
  endtask

  bit dir_seq [] = '{1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 0, 1, 1, 1};

  initial begin
    rst_n = 1'b0;
    in_b  = 1'b0;
    upd_b = 1'b0;
    model_reset();
    #3;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (dir_seq[k]) send_sample(dir_seq[k], 3);
    do_reset(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) send_sample(1'b1, 3);

    for (int k = 0; k < 180; k++) begin
      if (k % 60 == 59) do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      send_sample(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(20, 300) : $urandom_range(3, 4));
    end
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) send_sample(1'($urandom_range(0, 1)), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
